// File: rtl/twiddle_loader32.sv
// Writable twiddle store for the 32-point FFT: serial coefficient load into an 8x4 table,
// then 32-cycle playback on a 4-lane bus in either butterfly-stage ordering.
module twiddle_loader32 #(
  parameter int unsigned NB    = 9,
  parameter int unsigned LANES = 4,
  parameter int unsigned WORDS = 8
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                LOAD_START,
  input  logic                IN_VALID,
  output logic                IN_READY,
  input  logic [NB-1:0]       IN_WR,
  input  logic [NB-1:0]       IN_WI,
  output logic                LOAD_DONE,
  output logic                LOADED,
  input  logic                START,
  input  logic                STAGE,
  output logic [NB*LANES-1:0] OR,
  output logic [NB*LANES-1:0] OI,
  output logic                OUT_VALID,
  output logic                RDY
);

  localparam int unsigned WW = NB * LANES;
  localparam int unsigned BW = NB * (LANES - 1);

  typedef enum logic [1:0] {StIdle, StLoad, StPlay} state_e;

  state_e        state_q, state_d;
  logic [4:0]    wptr_q, wptr_d;
  logic [4:0]    pcnt_q, pcnt_d;
  logic          stage_q, stage_d;
  logic          in_ready_q, in_ready_d;
  logic          load_done_q, load_done_d;
  logic          loaded_q, loaded_d;
  logic          out_valid_q, out_valid_d;
  logic          rdy_q, rdy_d;
  logic [WW-1:0] or_q, or_d;
  logic [WW-1:0] oi_q, oi_d;
  logic          accept;
  logic          tab_we;

  // Lanes 0..2 of the word being assembled; lane 3 comes straight from the input.
  logic [BW-1:0] buf_r_q, buf_i_q;
  logic [WW-1:0] tab_r_q [WORDS];
  logic [WW-1:0] tab_i_q [WORDS];

  // STAGE=1 replays word 0 for the first half and word 4 for the second.
  function automatic logic [2:0] word_idx(input logic [4:0] p, input logic st);
    return st ? {p[4], 2'b00} : p[4:2];
  endfunction

  always_comb begin
    state_d     = state_q;
    wptr_d      = wptr_q;
    pcnt_d      = pcnt_q;
    stage_d     = stage_q;
    in_ready_d  = in_ready_q;
    load_done_d = 1'b0;
    loaded_d    = loaded_q;
    out_valid_d = 1'b0;
    rdy_d       = 1'b0;
    or_d        = or_q;
    oi_d        = oi_q;
    accept      = 1'b0;
    tab_we      = 1'b0;

    unique case (state_q)
      StIdle: begin
        in_ready_d = 1'b0;
        if (LOAD_START) begin
          state_d    = StLoad;
          wptr_d     = '0;
          loaded_d   = 1'b0;
          in_ready_d = 1'b1;
        end else if (START && loaded_q) begin
          state_d     = StPlay;
          pcnt_d      = '0;
          stage_d     = STAGE;
          out_valid_d = 1'b1;
        end
      end
      StLoad: begin
        if (LOAD_START) begin
          wptr_d     = '0;
          in_ready_d = 1'b1;
        end else if (IN_VALID && in_ready_q) begin
          accept = 1'b1;
          wptr_d = wptr_q + 5'd1;
          tab_we = (wptr_q[1:0] == 2'd3);
          if (wptr_q == 5'd31) begin
            state_d     = StIdle;
            in_ready_d  = 1'b0;
            loaded_d    = 1'b1;
            load_done_d = 1'b1;
          end
        end
      end
      StPlay: begin
        if (LOAD_START) begin
          state_d    = StLoad;
          wptr_d     = '0;
          loaded_d   = 1'b0;
          in_ready_d = 1'b1;
        end else if (START) begin
          pcnt_d      = '0;
          stage_d     = STAGE;
          out_valid_d = 1'b1;
        end else if (pcnt_q == 5'd31) begin
          state_d = StIdle;
        end else begin
          pcnt_d      = pcnt_q + 5'd1;
          out_valid_d = 1'b1;
          rdy_d       = (pcnt_q == 5'd30);
        end
      end
      default: state_d = StIdle;
    endcase

    if (out_valid_d) begin
      or_d = tab_r_q[word_idx(pcnt_d, stage_d)];
      oi_d = tab_i_q[word_idx(pcnt_d, stage_d)];
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q     <= StIdle;
      wptr_q      <= '0;
      pcnt_q      <= '0;
      stage_q     <= 1'b0;
      in_ready_q  <= 1'b0;
      load_done_q <= 1'b0;
      loaded_q    <= 1'b0;
      out_valid_q <= 1'b0;
      rdy_q       <= 1'b0;
      or_q        <= '0;
      oi_q        <= '0;
      buf_r_q     <= '0;
      buf_i_q     <= '0;
      for (int w = 0; w < WORDS; w++) begin
        tab_r_q[w] <= '0;
        tab_i_q[w] <= '0;
      end
    end else begin
      state_q     <= state_d;
      wptr_q      <= wptr_d;
      pcnt_q      <= pcnt_d;
      stage_q     <= stage_d;
      in_ready_q  <= in_ready_d;
      load_done_q <= load_done_d;
      loaded_q    <= loaded_d;
      out_valid_q <= out_valid_d;
      rdy_q       <= rdy_d;
      or_q        <= or_d;
      oi_q        <= oi_d;
      for (int k = 0; k < LANES - 1; k++) begin
        if (accept && wptr_q[1:0] == 2'(k)) begin
          buf_r_q[NB*k +: NB] <= IN_WR;
          buf_i_q[NB*k +: NB] <= IN_WI;
        end
      end
      if (tab_we) begin
        tab_r_q[wptr_q[4:2]] <= {IN_WR, buf_r_q};
        tab_i_q[wptr_q[4:2]] <= {IN_WI, buf_i_q};
      end
    end
  end

  assign IN_READY  = in_ready_q;
  assign LOAD_DONE = load_done_q;
  assign LOADED    = loaded_q;
  assign OUT_VALID = out_valid_q;
  assign RDY       = rdy_q;
  assign OR        = or_q;
  assign OI        = oi_q;

endmodule

// File: tb/tb_twiddle_loader32.sv
// Scoreboard bench for twiddle_loader32: stimulus pushes expected playback words, a negedge
// monitor pops and compares every OUT_VALID beat.
module tb_twiddle_loader32;

  localparam int NB = 9;
  localparam int W  = 4 * NB;

  logic          CLK = 1'b0;
  logic          RST = 1'b0;
  logic          LOAD_START = 1'b0;
  logic          IN_VALID = 1'b0;
  logic          START = 1'b0;
  logic          STAGE = 1'b0;
  logic [NB-1:0] IN_WR = '0;
  logic [NB-1:0] IN_WI = '0;
  logic          IN_READY, LOAD_DONE, LOADED, OUT_VALID, RDY;
  logic [W-1:0]  OR, OI;

  always #5 CLK = ~CLK;

  twiddle_loader32 dut (
    .CLK        (CLK),
    .RST        (RST),
    .LOAD_START (LOAD_START),
    .IN_VALID   (IN_VALID),
    .IN_READY   (IN_READY),
    .IN_WR      (IN_WR),
    .IN_WI      (IN_WI),
    .LOAD_DONE  (LOAD_DONE),
    .LOADED     (LOADED),
    .START      (START),
    .STAGE      (STAGE),
    .OR         (OR),
    .OI         (OI),
    .OUT_VALID  (OUT_VALID),
    .RDY        (RDY)
  );

  typedef struct packed {
    logic         rdy;
    logic [W-1:0] r;
    logic [W-1:0] i;
  } exp_t;

  exp_t          exp_q[$];
  logic [NB-1:0] mem_r [32];
  logic [NB-1:0] mem_i [32];
  int            n_pass = 0;
  int            n_total = 0;
  int            rdy_cnt = 0;
  int            done_cnt = 0;
  int            run_len = 0;
  int            last_run = 0;

  task automatic check(input string name, input logic [79:0] act, input logic [79:0] req);
    n_total++;
    if (act !== req) $display("FAIL %s: got %h required %h", name, act, req);
    else n_pass++;
  endtask

  always @(negedge CLK) begin : monitor
    exp_t e;
    if (RDY) rdy_cnt++;
    if (LOAD_DONE) done_cnt++;
    if (OUT_VALID) begin
      run_len++;
      if (exp_q.size() == 0) begin
        check("unexpected_valid", 80'd1, 80'd0);
      end else begin
        e = exp_q.pop_front();
        check("play_word", 80'({RDY, OR, OI}), 80'(e));
      end
    end else if (run_len != 0) begin
      last_run = run_len;
      run_len  = 0;
    end
  end

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  function automatic exp_t mk(input int p, input logic st);
    exp_t e;
    int   w;
    w = st ? ((p >= 16) ? 4 : 0) : p / 4;
    for (int k = 0; k < 4; k++) begin
      e.r[NB*k +: NB] = mem_r[4*w+k];
      e.i[NB*k +: NB] = mem_i[4*w+k];
    end
    e.rdy = (p == 31);
    return e;
  endfunction

  task automatic push_play(input int first, input int last, input logic st);
    for (int p = first; p <= last; p++) exp_q.push_back(mk(p, st));
  endtask

  task automatic pulse_start(input logic st);
    START = 1'b1;
    STAGE = st;
    step();
    START = 1'b0;
    STAGE = ~st;
  endtask

  task automatic drain(input string name);
    for (int c = 0; c < 60 && exp_q.size() != 0; c++) step();
    check(name, 80'(exp_q.size()), 80'd0);
    exp_q.delete();
    step();
    step();
  endtask

  task automatic load_set(input int mode);
    logic rd;
    LOAD_START = 1'b1;
    step();
    LOAD_START = 1'b0;
    for (int n = 0; n < 32; n++) begin
      mem_r[n] = (mode == 0) ? NB'(n) : NB'((n * 7 + 3) & 'h1FF);
      mem_i[n] = (mode == 0) ? NB'(~n & 'h1FF) : NB'(n ^ 'h0AA);
      IN_WR    = mem_r[n];
      IN_WI    = mem_i[n];
      IN_VALID = 1'b1;
      rd       = 1'b0;
      for (int c = 0; c < 5 && !rd; c++) begin
        @(negedge CLK);
        rd = IN_READY;
        @(posedge CLK);
        #1;
      end
      if (!rd) begin
        check("in_ready_timeout", 80'd0, 80'd1);
        break;
      end
      IN_VALID = 1'b0;
      if (n != 31) begin
        IN_WR = 9'h155;
        IN_WI = 9'h0AA;
        step();
      end
    end
  endtask

  initial begin
    RST = 1'b0;
    #2;
    check("reset_outputs", 80'({OR, OI, OUT_VALID, RDY, LOADED, IN_READY, LOAD_DONE}), 80'd0);
    @(posedge CLK);
    #1;
    RST = 1'b1;
    step();

    // START with nothing loaded must not play
    pulse_start(1'b0);
    repeat (3) step();
    check("start_unloaded", 80'(OUT_VALID), 80'd0);
    check("loaded_idle", 80'(LOADED), 80'd0);

    // T2: load with IN_VALID toggling
    done_cnt = 0;
    load_set(0);
    check("load_done_pulse", 80'(LOAD_DONE), 80'd1);
    check("ready_after_last", 80'(IN_READY), 80'd0);
    check("loaded_set", 80'(LOADED), 80'd1);
    step();
    check("load_done_once", 80'(LOAD_DONE), 80'd0);
    check("load_done_count", 80'(done_cnt), 80'd1);

    // T3: STAGE=0 playback; stray IN_VALID must be ignored
    rdy_cnt = 0;
    push_play(0, 31, 1'b0);
    IN_VALID = 1'b1;
    IN_WR    = 9'h1FF;
    pulse_start(1'b0);
    drain("stage0_drain");
    IN_VALID = 1'b0;
    check("stage0_rdy_count", 80'(rdy_cnt), 80'd1);
    check("stage0_run", 80'(last_run), 80'd32);
    check("stage0_idle", 80'({OUT_VALID, RDY}), 80'd0);
    check("stage0_hold_or", 80'(OR), 80'((36'd31 << 27) | (36'd30 << 18) | (36'd29 << 9) | 36'd28));

    // T4: STAGE=1 playback
    rdy_cnt = 0;
    push_play(0, 31, 1'b1);
    pulse_start(1'b1);
    check("stage1_first_or", 80'(OR), 80'((36'd3 << 27) | (36'd2 << 18) | (36'd1 << 9) | 36'd0));
    drain("stage1_drain");
    check("stage1_rdy_count", 80'(rdy_cnt), 80'd1);
    check("stage1_hold_or", 80'(OR), 80'((36'd19 << 27) | (36'd18 << 18) | (36'd17 << 9) | 36'd16));
    check("loaded_after_play", 80'(LOADED), 80'd1);

    // T5: restart mid-play, 10 + 32 contiguous beats, one RDY
    rdy_cnt = 0;
    push_play(0, 9, 1'b0);
    push_play(0, 31, 1'b1);
    pulse_start(1'b0);
    repeat (9) step();
    pulse_start(1'b1);
    drain("restart_drain");
    check("restart_rdy_count", 80'(rdy_cnt), 80'd1);
    check("restart_run", 80'(last_run), 80'd42);

    // T6: LOAD_START and START together during PLAY
    rdy_cnt = 0;
    push_play(0, 4, 1'b0);
    pulse_start(1'b0);
    repeat (4) step();
    LOAD_START = 1'b1;
    START      = 1'b1;
    step();
    LOAD_START = 1'b0;
    START      = 1'b0;
    check("abort_outputs", 80'({OUT_VALID, RDY, LOADED, IN_READY}), 80'b0001);
    check("abort_queue", 80'(exp_q.size()), 80'd0);
    load_set(1);
    step();
    check("abort_rdy_count", 80'(rdy_cnt), 80'd0);
    push_play(0, 31, 1'b0);
    pulse_start(1'b0);
    drain("reload_drain");
    check("reload_rdy_count", 80'(rdy_cnt), 80'd1);

    // T1: async reset mid-play
    push_play(0, 31, 1'b1);
    pulse_start(1'b1);
    repeat (3) step();
    RST = 1'b0;
    #1;
    exp_q.delete();
    check("async_reset", 80'({OR, OI, OUT_VALID, RDY, LOADED, IN_READY}), 80'd0);
    step();
    RST = 1'b1;
    step();
    pulse_start(1'b0);
    repeat (3) step();
    check("start_after_reset", 80'(OUT_VALID), 80'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running required finished");
    $fatal(1);
  end

endmodule
